note_select: RTL

NOTE_SELECT -- requirements
Module: note_select

---
 rtl/synth_pkg.sv | 32 +++
 rtl/note_select_debounce.sv | 60 ++++++
 rtl/note_select.sv | 87 ++++++++
 3 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module  : synth_pkg
// Brief   : Shared clock constant, C4..B4 divider table and note/octave types.
// Revision: 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int CLK_HZ = 10_000_000;

    // round(CLK_HZ / f) for C4 through B4
    localparam logic [15:0] BASE_DIV [0:11] = '{
        16'd38223, 16'd36077, 16'd34052, 16'd32141,
        16'd30337, 16'd28635, 16'd27027, 16'd25511,
        16'd24079, 16'd22727, 16'd21452, 16'd20248
    };

    typedef logic [3:0] note_idx_t;
    typedef logic [1:0] octave_t;

    // Lowest-index pressed key wins; returns 0 when nothing is pressed.
    function automatic note_idx_t lowest_set(input logic [11:0] k);
        note_idx_t idx;
        idx = '0;
        for (int i = 11; i >= 0; i--) begin
            if (k[i]) idx = note_idx_t'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_select_debounce.sv
`default_nettype none
// ============================================================================
// Module  : debounce
// Brief   : 2-flop synchronizer plus one debounce counter shared by all bits.
// Revision: 1.0 - initial release
// ============================================================================
module debounce #(
    parameter int WIDTH  = 14,
    parameter int CYCLES = 10000
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_deb,
    output logic [WIDTH-1:0] o_rise
);

    localparam int             CW     = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_rise;
    logic [CW-1:0]    r_cnt;
    logic             w_change;

    // r_sync2 takes r_sync1 on the next edge, so a mismatch means the
    // synchronized vector is changing this cycle.
    assign w_change = (r_sync1 != r_sync2);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_rise  <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= '0;
            if (w_change) begin
                r_cnt <= '0;
            end else if (r_cnt != C_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                // Saturated: re-latching an unchanged vector is harmless and
                // produces no rise pulse.
                r_deb  <= r_sync2;
                r_rise <= r_sync2 & ~r_deb;
            end
        end
    end

    assign o_deb  = r_deb;
    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/note_select.sv
`default_nettype none
// ============================================================================
// Module  : note_select
// Brief   : Debounced keyboard/octave buttons to a registered period divider.
// Revision: 1.0 - initial release
// ============================================================================
module note_select
    import synth_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [11:0] keys,
    input  logic        oct_up,
    input  logic        oct_dn,
    output logic [15:0] divider,
    output logic        note_on,
    output logic [1:0]  octave
);

    logic [13:0] w_raw;
    logic [13:0] w_deb;
    logic [13:0] w_rise;
    logic [11:0] w_keys;
    logic        w_up_rise;
    logic        w_dn_rise;
    logic        w_any_key;
    note_idx_t   w_idx;
    octave_t     w_oct_next;
    logic [15:0] w_div_next;

    octave_t     r_octave;
    logic [15:0] r_divider;
    logic        r_note_on;

    assign w_raw = {oct_dn, oct_up, keys};

    debounce #(
        .WIDTH  (14),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .nrst   (nrst),
        .i_raw  (w_raw),
        .o_deb  (w_deb),
        .o_rise (w_rise)
    );

    assign w_keys    = w_deb[11:0];
    assign w_up_rise = w_rise[12];
    assign w_dn_rise = w_rise[13];
    assign w_any_key = |w_keys;
    assign w_idx     = lowest_set(w_keys);

    always_comb begin
        w_oct_next = r_octave;
        if (w_up_rise && !w_dn_rise && (r_octave != 2'd3)) begin
            w_oct_next = r_octave + 2'd1;
        end else if (w_dn_rise && !w_up_rise && (r_octave != 2'd0)) begin
            w_oct_next = r_octave - 2'd1;
        end
    end

    // Using the next octave lets the divider step straight to the new value.
    assign w_div_next = BASE_DIV[w_idx] >> w_oct_next;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_octave  <= '0;
            r_divider <= '0;
            r_note_on <= 1'b0;
        end else begin
            r_octave  <= w_oct_next;
            r_note_on <= w_any_key;
            if (w_any_key) begin
                r_divider <= w_div_next;
            end
        end
    end

    assign divider = r_divider;
    assign note_on = r_note_on;
    assign octave  = r_octave;

endmodule
`default_nettype wire
